// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, strobe bundle
// and default watchdog sizing.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } ctrlState_t;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 64;
  localparam int unsigned DEFAULT_CNT_W       = 10;

  typedef struct packed {
    logic freezePC;
    logic freezeIFID;
    logic flushIFID;
    logic freezeIDEX;
    logic flushIDEX;
    logic freezeEXMEM;
    logic freezeMEMWB;
  } strobes_t;

  localparam strobes_t STROBES_NONE   = '0;
  localparam strobes_t STROBES_FLUSH  = '{freezePC: 1'b0, freezeIFID: 1'b0, flushIFID: 1'b1,
                                          freezeIDEX: 1'b0, flushIDEX: 1'b1,
                                          freezeEXMEM: 1'b0, freezeMEMWB: 1'b0};
  localparam strobes_t STROBES_FREEZE = '{freezePC: 1'b1, freezeIFID: 1'b1, flushIFID: 1'b0,
                                          freezeIDEX: 1'b1, flushIDEX: 1'b0,
                                          freezeEXMEM: 1'b1, freezeMEMWB: 1'b1};
  localparam strobes_t STROBES_BUBBLE = '{freezePC: 1'b1, freezeIFID: 1'b1, flushIFID: 1'b0,
                                          freezeIDEX: 1'b0, flushIDEX: 1'b1,
                                          freezeEXMEM: 1'b0, freezeMEMWB: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Event inputs and freeze/flush strobes between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if;

  logic        hazard;
  logic        branchTaken;
  logic        memReq;
  logic        memReady;
  logic        freezePC;
  logic        freezeIFID;
  logic        flushIFID;
  logic        freezeIDEX;
  logic        flushIDEX;
  logic        freezeEXMEM;
  logic        freezeMEMWB;
  logic        memTimeout;
  logic [31:0] stallCount;
  logic [31:0] flushCount;

  modport master (
    output hazard, branchTaken, memReq, memReady,
    input  freezePC, freezeIFID, flushIFID, freezeIDEX, flushIDEX,
           freezeEXMEM, freezeMEMWB, memTimeout, stallCount, flushCount
  );

  modport slave (
    input  hazard, branchTaken, memReq, memReady,
    output freezePC, freezeIFID, flushIFID, freezeIDEX, flushIDEX,
           freezeEXMEM, freezeMEMWB, memTimeout, stallCount, flushCount
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Memory-wait watchdog: counts consecutive not-ready cycles and holds the
// sticky timeout flag until reset.
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic cntLoad,
  input  logic cntInc,
  input  logic cntClr,
  input  logic timeoutSet,
  output logic atLimit,
  output logic memTimeout
);

  logic [CNT_W-1:0] waitCnt;

  // NOTE: reset is asynchronous and active-low; the sensitivity list must name
  // its falling edge so the flops clear without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (cntClr) begin
      waitCnt <= '0;
    end else if (cntLoad) begin
      waitCnt <= CNT_W'(1);
    end else if (cntInc) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memTimeout <= 1'b0;
    end else if (timeoutSet) begin
      memTimeout <= 1'b1;
    end
  end

  assign atLimit = (waitCnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush arbiter for load-use, taken-branch and slow-memory events.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave ctrl
);

  ctrlState_t state;
  strobes_t   strobes;
  logic       memMiss;
  logic       memStall;
  logic       branchFlush;
  logic       atLimit;
  logic       memTimeout;

  assign memMiss = ctrl.memReq && !ctrl.memReady;

  assign memStall = (state == RUN && memMiss) ||
                    (state == MEM_WAIT && !ctrl.memReady) ||
                    (state == TIMEOUT);

  assign branchFlush = !memStall && ctrl.branchTaken;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    strobes = STROBES_NONE;
    if (!rst) begin
      strobes = STROBES_FLUSH;
    end else if (memStall) begin
      strobes = STROBES_FREEZE;
    end else if (branchFlush) begin
      strobes = STROBES_FLUSH;
    end else if (ctrl.hazard) begin
      strobes = STROBES_BUBBLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:      if (memMiss) state <= MEM_WAIT;
        MEM_WAIT: begin
          // A dropped request is treated like a completed access.
          if (ctrl.memReady || !ctrl.memReq) state <= RUN;
          else if (atLimit)                  state <= TIMEOUT;
        end
        TIMEOUT:  state <= TIMEOUT;
        default:  state <= RUN;
      endcase
    end
  end

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .cntLoad    (state == RUN && memMiss),
    .cntInc     (state == MEM_WAIT && memMiss && !atLimit),
    .cntClr     (state == MEM_WAIT && (ctrl.memReady || !ctrl.memReq)),
    .timeoutSet (state == MEM_WAIT && memMiss && atLimit),
    .atLimit    (atLimit),
    .memTimeout (memTimeout)
  );

  assign ctrl.freezePC    = strobes.freezePC;
  assign ctrl.freezeIFID  = strobes.freezeIFID;
  assign ctrl.flushIFID   = strobes.flushIFID;
  assign ctrl.freezeIDEX  = strobes.freezeIDEX;
  assign ctrl.flushIDEX   = strobes.flushIDEX;
  assign ctrl.freezeEXMEM = strobes.freezeEXMEM;
  assign ctrl.freezeMEMWB = strobes.freezeMEMWB;
  assign ctrl.memTimeout  = memTimeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (strobes.freezePC && state != TIMEOUT && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
      if (branchFlush && flushCnt != '1)                          flushCnt <= flushCnt + 1'b1;
    end
  end

  assign ctrl.stallCount = stallCnt;
  assign ctrl.flushCount = flushCnt;
`else
  assign ctrl.stallCount = '0;
  assign ctrl.flushCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); honours
// HAZARD_PERF_CNT_EN for the counter expectations.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {freezePC, freezeIFID, flushIFID, freezeIDEX, flushIDEX, freezeEXMEM, freezeMEMWB, memTimeout}
  localparam logic [7:0] V_NONE  = 8'b0000_0000;
  localparam logic [7:0] V_RST   = 8'b0010_1000;
  localparam logic [7:0] V_FLUSH = 8'b0010_1000;
  localparam logic [7:0] V_HAZ   = 8'b1100_1000;
  localparam logic [7:0] V_FRZ   = 8'b1101_0110;
  localparam logic [7:0] V_TOUT  = 8'b1101_0111;

  typedef struct {
    string      tag;
    logic [7:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  exp_t        sb[$];
  int          passCnt  = 0;
  int          totalCnt = 0;
  logic [31:0] expStall = '0;
  logic [31:0] expFlush = '0;

  function automatic logic [7:0] obsVec();
    return {bus.freezePC, bus.freezeIFID, bus.flushIFID, bus.freezeIDEX,
            bus.flushIDEX, bus.freezeEXMEM, bus.freezeMEMWB, bus.memTimeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic compareAll(input string tag, input logic [7:0] vec);
    check(tag, {24'd0, obsVec()}, {24'd0, vec});
    check({tag, "_stallCount"}, bus.stallCount, expStall);
    check({tag, "_flushCount"}, bus.flushCount, expFlush);
  endtask

  // Accounts the cycle just checked into the counter model (takes effect at the next edge).
  task automatic modelCounters(input logic [7:0] vec);
    if (PERF && rst) begin
      if (vec[7] && !vec[0]) expStall++;
      if (vec[5] && !vec[7]) expFlush++;
    end
    if (!rst) begin
      expStall = '0;
      expFlush = '0;
    end
  endtask

  // Called at a falling edge: drive, push expectation, sample mid-cycle, advance.
  task automatic step(input string tag, input bit h, input bit br, input bit rq,
                      input bit rd, input logic [7:0] vec);
    exp_t e;
    bus.hazard      = h;
    bus.branchTaken = br;
    bus.memReq      = rq;
    bus.memReady    = rd;
    sb.push_back('{tag: tag, vec: vec});
    #2;
    e = sb.pop_front();
    compareAll(e.tag, e.vec);
    modelCounters(e.vec);
    @(negedge clk);
  endtask

  initial begin
    bus.hazard      = 1'b0;
    bus.branchTaken = 1'b0;
    bus.memReq      = 1'b0;
    bus.memReady    = 1'b0;
    @(negedge clk);

    // Reset: pipeline cleared, requests ignored.
    step("rst0", 0, 0, 0, 0, V_RST);
    step("rst_memreq", 1, 1, 1, 0, V_RST);
    rst = 1'b1;
    step("idle", 0, 0, 0, 0, V_NONE);

    // Load-use bubble and branch priority.
    step("haz", 1, 0, 0, 0, V_HAZ);
    step("haz_off", 0, 0, 0, 0, V_NONE);
    step("haz_br", 1, 1, 0, 0, V_FLUSH);
    step("br", 0, 1, 0, 0, V_FLUSH);
    step("idle2", 0, 0, 0, 0, V_NONE);

    // Three-cycle memory wait.
    step("mw1", 0, 0, 1, 0, V_FRZ);
    step("mw2", 0, 0, 1, 0, V_FRZ);
    step("mw3", 0, 0, 1, 0, V_FRZ);
    step("mw_rdy", 0, 0, 1, 1, V_NONE);
    step("mw_run", 0, 0, 0, 0, V_NONE);

    // Same-cycle hit must not enter the wait state.
    step("hit", 0, 0, 1, 1, V_NONE);
    step("hit_after", 1, 0, 0, 0, V_HAZ);

    // Branch held through a memory wait is honoured on memReady.
    step("bw1", 0, 1, 1, 0, V_FRZ);
    step("bw2", 1, 1, 1, 0, V_FRZ);
    step("bw3", 0, 1, 1, 0, V_FRZ);
    step("bw_rdy", 0, 1, 1, 1, V_FLUSH);
    step("bw_done", 0, 0, 0, 0, V_NONE);

    // Asynchronous reset on wait cycle 2.
    step("ar_w1", 0, 0, 1, 0, V_FRZ);
    step("ar_w2", 0, 0, 1, 0, V_FRZ);
    bus.memReq   = 1'b1;
    bus.memReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    modelCounters(V_RST);
    compareAll("async_rst", V_RST);
    @(negedge clk);
    rst = 1'b1;
    step("ar_idle", 0, 0, 0, 0, V_NONE);

    // Watchdog: five stalled edges from a cleared counter reach TIMEOUT.
    step("to1", 0, 0, 1, 0, V_FRZ);
    step("to2", 0, 0, 1, 0, V_FRZ);
    step("to3", 0, 0, 1, 0, V_FRZ);
    step("to4", 0, 0, 1, 0, V_FRZ);
    step("to5", 0, 0, 1, 0, V_FRZ);
    step("to_hit", 0, 0, 1, 0, V_TOUT);
    step("to_rdy", 0, 1, 1, 1, V_TOUT);
    step("to_idle", 1, 0, 0, 0, V_TOUT);
    rst = 1'b0;
    step("to_rst", 0, 0, 0, 0, V_RST);
    rst = 1'b1;
    step("to_clear", 0, 0, 0, 0, V_NONE);
    step("to_haz", 1, 0, 0, 0, V_HAZ);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
